clk_en_gen: RTL and testbench
=============================

# clk_en_gen

Multi-channel clock-enable generator for the 108 MHz `CLK` domain. It produces single-cycle `CLK_EN` strobes at fractional or integer-divided rates, for example the 21.6 MHz DAC strobe, the 3.58 MHz bus and UMA rate, and the 14/21/25 MHz video rates. It generalises the fixed ÷5 DAC counter to `CHANNELS` independent channels with:
- a per-channel mode;
- glitch-free retuning at strobe boundaries;
- a global phase-align input.

It sits beside the bus and UMA logic and feeds their `CLK_EN` inputs.

## Interface
Parameters:
- `CHANNELS`, 4: number of independent enable channels.
- `ACC_WIDTH`, 24: accumulator and counter width W; fractional rate = `INC`/2^W × f_CLK.

Ports:
- `CLK`, in, 1: system clock (108 MHz).
- `RESET`, in, 1: reset, synchronous, active-high.
- `RUN`, in, CHANNELS: per-channel run enable.
- `MODE`, in, CHANNELS: per-channel mode; 0 = fractional accumulator, 1 = integer divider.
- `INC`, in, CHANNELS×W: per-channel increment (mode 0) or divisor N (mode 1); channel c occupies bits [c*W +: W].
- `LOAD`, in, 1: strobe that captures all `INC`/`MODE` into shadow registers.
- `SYNC`, in, 1: strobe that phase-aligns all channels.
- `CLK_EN`, out, CHANNELS: registered single-cycle enable strobes.
- `PENDING`, out, CHANNELS: a shadow value is captured but not yet active.

## Operation
- Per-channel state:
  - `acc` (W bits): accumulator or down-counter.
  - `act_inc`, `act_mode`: active settings.
  - `sh_inc`, `sh_mode`: shadow settings.
  - `pend`: pending flag, driven on `PENDING`.
- Mode 0, when `RUN` is high: `{carry, acc} <= acc + act_inc` ((W+1)-bit sum). `CLK_EN <= carry`.
  - `act_inc` = 0 never fires.
- Mode 1, when `RUN` is high:
  - If `acc` == 0: `acc <= max(act_inc,1) - 1` and `CLK_EN <= 1`.
  - Otherwise: `acc <= acc - 1` and `CLK_EN <= 0`.
  - Result: one strobe every max(N,1) cycles; N = 0 or N = 1 gives a strobe every cycle.
- `RUN` low: `acc` holds and `CLK_EN <= 0`.
- `LOAD`: every channel does `sh_* <= INC/MODE` and `pend <= 1`. A second `LOAD` before apply overwrites the shadow, with `pend` remaining 1.
- Apply of a pending setting (`act_* <= sh_*`, `acc <= 0`, `pend <= 0`) happens on the first cycle after capture in which any of these holds:
  - the channel's `CLK_EN` is asserted;
  - `RUN` is low;
  - `SYNC` is high.
- The apply cycle itself produces no strobe. The new setting governs from the following cycle.
- `SYNC`:
  - Every channel's `acc <= 0` and `CLK_EN <= 0` for that cycle.
  - Pending settings apply in the same cycle.
  - Channels then restart in lock-step.
- Simultaneous `LOAD` and `SYNC`: the capture happens this cycle and the apply happens in the next eligible cycle. `SYNC` does not apply a value being captured in the same cycle.
- Changing `INC`/`MODE` without `LOAD` has no effect.

## Timing
- Reset values: `CLK_EN` = 0, `PENDING` = 0, `acc` = 0, `act_inc` = 0, `act_mode` = 0, `sh_*` = 0. All channels are silent until the first `LOAD`.
- `RESET` mid-operation: all state returns to the reset values on the next edge and any pending shadow is discarded.
- Latency, mode 0: `RUN` rises at edge 0 with `acc` = 0. The first strobe is visible after edge k, where k = ceil(2^W/`act_inc`).
- Latency, mode 1: the first strobe is visible after edge 1, because `acc` = 0 on entry. Subsequent strobes follow every N cycles.
- `CLK_EN` is always exactly one cycle wide, except when the rate equals one strobe per cycle.
- Wrap-around: the mode 0 carry discards the overflow, so the long-run rate is exact with no drift. The mode 1 counter never underflows.
- `PENDING` falls on the same edge that the new setting becomes active.

## Test plan
- Mode 1, W = 8, N = 5, `LOAD` then `RUN` = 1: `CLK_EN` pulses every 5th cycle. Exactly 20 pulses in 100 cycles. `PENDING` is high for exactly 1 cycle.
- Mode 0, W = 8, `INC` = 0x40: period 4 cycles, first pulse 4 cycles after `RUN`. With `INC` = 0x55: 85 pulses in 256 cycles, inter-pulse gaps of only 3 or 4.
- Retune: channel 0 runs at N = 10; `LOAD` with N = 3 issued mid-period. `PENDING` stays high until the next pulse, then the gaps are 1 (apply cycle), then every 3 cycles. No pulse narrower or shorter-spaced than specified.
- `SYNC` with 4 channels at N = 2, 3, 4, 6 and different phases: all `CLK_EN` are 0 in the `SYNC` cycle, and all four pulse together on the next cycle and every 12 cycles thereafter.
- Edge values: N = 0 and N = 1 both give a pulse every cycle. Mode 0 `INC` = 0 gives no pulse in 1000 cycles. `INC` = 0xFF gives 255 pulses per 256 cycles.
- `RESET` asserted mid-stream for 1 cycle: `CLK_EN` = 0 and `PENDING` = 0 on the next edge. No pulses appear until a new `LOAD`, even with `RUN` held high.

Source files
------------

// File: rtl/clk_en_gen_if.sv
// ---------------------------------------------------------------------------
// clk_en_gen_if
//   Control/strobe bundle between a rate-programming master (bus/UMA control)
//   and the clk_en_gen enable generator.
//
//   RUN     [CHANNELS]           per-channel run enable
//   MODE    [CHANNELS]           0 = fractional accumulator, 1 = integer divider
//   INC     [CHANNELS*ACC_WIDTH] increment / divisor, channel c at [c*W +: W]
//   LOAD                         capture all INC/MODE into the shadow registers
//   SYNC                         phase-align all channels
//   CLK_EN  [CHANNELS]           registered single-cycle enable strobes
//   PENDING [CHANNELS]           shadow captured but not yet active
// ---------------------------------------------------------------------------
interface clk_en_gen_if #(
    parameter int CHANNELS  = 4,
    parameter int ACC_WIDTH = 24
);
    logic [CHANNELS-1:0]           RUN;
    logic [CHANNELS-1:0]           MODE;
    logic [CHANNELS*ACC_WIDTH-1:0] INC;
    logic                          LOAD;
    logic                          SYNC;
    logic [CHANNELS-1:0]           CLK_EN;
    logic [CHANNELS-1:0]           PENDING;

    modport master (
        output RUN, MODE, INC, LOAD, SYNC,
        input  CLK_EN, PENDING
    );

    modport slave (
        input  RUN, MODE, INC, LOAD, SYNC,
        output CLK_EN, PENDING
    );
endinterface

// File: rtl/clk_en_gen.sv
// ---------------------------------------------------------------------------
// clk_en_gen
//   Multi-channel clock-enable generator for the 108 MHz CLK domain. Each
//   channel emits single-cycle CLK_EN strobes either from a fractional phase
//   accumulator (rate = INC/2^W * f_CLK) or from an integer divide-by-N
//   down-counter. New settings are staged in shadow registers by LOAD and
//   only take effect on a strobe boundary, while the channel is stopped, or
//   on SYNC, so a retune never produces a runt or over-short interval.
//
//   CLK    in   system clock
//   RESET  in   synchronous, active-high reset
//   bus    slave modport of clk_en_gen_if (RUN/MODE/INC/LOAD/SYNC in,
//               CLK_EN/PENDING out)
// ---------------------------------------------------------------------------
module clk_en_gen #(
    parameter int CHANNELS  = 4,
    parameter int ACC_WIDTH = 24
) (
    input  logic         CLK,
    input  logic         RESET,
    clk_en_gen_if.slave  bus
);

    localparam int W = ACC_WIDTH;

    // Per-channel state
    logic [W-1:0]        acc      [CHANNELS];
    logic [W-1:0]        act_inc  [CHANNELS];
    logic [W-1:0]        sh_inc   [CHANNELS];
    logic [CHANNELS-1:0] act_mode;
    logic [CHANNELS-1:0] sh_mode;
    logic [CHANNELS-1:0] pend;
    logic [CHANNELS-1:0] en_q;

    // Combinational helpers
    logic [W:0]          sum      [CHANNELS];   // {carry, acc + act_inc}
    logic [W-1:0]        reload   [CHANNELS];   // max(N,1) - 1
    logic [CHANNELS-1:0] apply;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path
        // leaves it unassigned and infers a latch.
        apply = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            sum[c]    = {1'b0, acc[c]} + {1'b0, act_inc[c]};
            reload[c] = (act_inc[c] == '0) ? '0 : act_inc[c] - 1'b1;
            // A pending setting goes live on a strobe boundary (the strobe
            // currently on CLK_EN), while stopped, or on SYNC. Using the
            // registered pend means a value captured this very cycle is
            // never applied in the same cycle.
            apply[c]  = pend[c] & (en_q[c] | ~bus.RUN[c] | bus.SYNC);
        end
    end

    // NOTE: all state below is sequential and uses non-blocking assignments so
    // every register samples the pre-edge values of its neighbours.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            act_mode <= '0;
            sh_mode  <= '0;
            pend     <= '0;
            en_q     <= '0;
            for (int c = 0; c < CHANNELS; c++) begin
                acc[c]     <= '0;
                act_inc[c] <= '0;
                sh_inc[c]  <= '0;
            end
        end else begin
            for (int c = 0; c < CHANNELS; c++) begin
                // Shadow capture; a newer LOAD simply overwrites.
                if (bus.LOAD) begin
                    sh_inc[c]  <= bus.INC[c*W +: W];
                    sh_mode[c] <= bus.MODE[c];
                end
                // A capture keeps the flag set even if an older shadow is
                // being applied in the same cycle.
                pend[c] <= bus.LOAD | (pend[c] & ~apply[c]);

                if (apply[c]) begin
                    // Apply cycle is silent; new setting governs from the next.
                    act_inc[c]  <= sh_inc[c];
                    act_mode[c] <= sh_mode[c];
                    acc[c]      <= '0;
                    en_q[c]     <= 1'b0;
                end else if (bus.SYNC) begin
                    acc[c]  <= '0;
                    en_q[c] <= 1'b0;
                end else if (!bus.RUN[c]) begin
                    en_q[c] <= 1'b0;
                end else if (!act_mode[c]) begin
                    // Fractional: overflow is dropped, so the rate never drifts.
                    acc[c]  <= sum[c][W-1:0];
                    en_q[c] <= sum[c][W];
                end else if (acc[c] == '0) begin
                    acc[c]  <= reload[c];
                    en_q[c] <= 1'b1;
                end else begin
                    acc[c]  <= acc[c] - 1'b1;
                    en_q[c] <= 1'b0;
                end
            end
        end
    end

    assign bus.CLK_EN  = en_q;
    assign bus.PENDING = pend;

endmodule

// File: tb/tb_clk_en_gen.sv
// ---------------------------------------------------------------------------
// tb_clk_en_gen
//   Directed bench for clk_en_gen with CHANNELS = 4, ACC_WIDTH = 8. The
//   stimulus process drives one cycle at a time and pushes the hand-derived
//   expectation for the outputs that cycle produces; a monitor pops and
//   compares at the falling edge.
// ---------------------------------------------------------------------------
module tb_clk_en_gen;

    localparam int CH = 4;
    localparam int W  = 8;

    logic clk;
    logic rst;

    clk_en_gen_if #(.CHANNELS(CH), .ACC_WIDTH(W)) bus ();

    clk_en_gen #(.CHANNELS(CH), .ACC_WIDTH(W)) dut (
        .CLK   (clk),
        .RESET (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- scoreboard ----------------
    typedef struct {
        string      nm;
        logic [3:0] ee;     // expected CLK_EN
        logic [3:0] em;     // CLK_EN compare mask
        logic [3:0] pe;     // expected PENDING
        logic [3:0] pm;     // PENDING compare mask
        bit         cc;     // clear channel-0 pulse counter before this sample
        bit         ck;     // check channel-0 pulse counter after this sample
        int         ce;     // expected count
    } exp_t;

    exp_t sb_q[$];
    exp_t it;
    int   n_cmp  = 0;
    int   n_fail = 0;
    int   cnt0   = 0;

    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            it = sb_q.pop_front();
            if (it.em != 4'b0) begin
                n_cmp++;
                if ((bus.CLK_EN & it.em) !== (it.ee & it.em)) begin
                    n_fail++;
                    $display("FAIL %s CLK_EN: got %b want %b (mask %b) at %0t",
                             it.nm, bus.CLK_EN, it.ee, it.em, $time);
                end
            end
            if (it.pm != 4'b0) begin
                n_cmp++;
                if ((bus.PENDING & it.pm) !== (it.pe & it.pm)) begin
                    n_fail++;
                    $display("FAIL %s PENDING: got %b want %b (mask %b) at %0t",
                             it.nm, bus.PENDING, it.pe, it.pm, $time);
                end
            end
            if (it.cc) cnt0 = 0;
            if (bus.CLK_EN[0] === 1'b1) cnt0++;
            if (it.ck) begin
                n_cmp++;
                if (cnt0 != it.ce) begin
                    n_fail++;
                    $display("FAIL %s pulse count: got %0d want %0d", it.nm, cnt0, it.ce);
                end
            end
        end
    end

    // Safety net: the run must never hang.
    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus helpers ----------------
    // One clock: inputs already set by the caller are sampled at the next
    // edge; the expectation for that edge's outputs is queued. LOAD and SYNC
    // are one-cycle strobes and are cleared afterwards.
    task automatic tick(input string nm, input logic [3:0] ee, input logic [3:0] em,
                        input logic [3:0] pe, input logic [3:0] pm,
                        input bit cc = 1'b0, input bit ck = 1'b0, input int ce = 0);
        exp_t e;
        @(posedge clk);
        e.nm = nm; e.ee = ee; e.em = em; e.pe = pe; e.pm = pm;
        e.cc = cc; e.ck = ck; e.ce = ce;
        sb_q.push_back(e);
        #1;
        bus.LOAD = 1'b0;
        bus.SYNC = 1'b0;
    endtask

    task automatic set_inc(input int c, input int v);
        bus.INC[c*W +: W] = v[W-1:0];
    endtask

    // LOAD with RUN low, then one more stopped cycle that applies the shadow.
    task automatic load_and_apply(input string nm);
        bus.RUN  = 4'b0000;
        bus.LOAD = 1'b1;
        tick({nm, "_load"},  4'b0000, 4'hF, 4'hF, 4'hF);
        tick({nm, "_apply"}, 4'b0000, 4'hF, 4'h0, 4'hF);
    endtask

    // Fractional carry at step k: integer part of k*inc/256 advances.
    function automatic bit frac_fire(input int k, input int inc);
        return ((k * inc) >> W) != (((k - 1) * inc) >> W);
    endfunction

    // ---------------- directed sequence ----------------
    initial begin
        logic [3:0] ee;
        int         nv[4];

        rst      = 1'b1;
        bus.RUN  = '0;
        bus.MODE = '0;
        bus.INC  = '0;
        bus.LOAD = 1'b0;
        bus.SYNC = 1'b0;
        #1;

        // Reset state
        tick("reset0", 4'b0, 4'hF, 4'b0, 4'hF);
        tick("reset1", 4'b0, 4'hF, 4'b0, 4'hF);
        rst = 1'b0;

        // Silent before any LOAD even while running
        bus.RUN = 4'hF;
        for (int i = 0; i < 8; i++) tick("silent_preload", 4'b0, 4'hF, 4'b0, 4'hF);

        // Mode 1, N = 5 on channel 0: strobes at steps 1, 6, 11, ...
        bus.MODE = 4'b0001;
        bus.INC  = '0;
        set_inc(0, 5);
        load_and_apply("div5");
        bus.RUN = 4'b0001;
        for (int i = 1; i <= 100; i++) begin
            if (i == 50) set_inc(0, 2);      // no LOAD: must be ignored
            ee = {3'b000, (i % 5) == 1};
            tick("div5_run", ee, 4'hF, 4'b0, 4'hF, i == 1, i == 100, 20);
        end

        // Mode 0, INC = 0x40: first strobe 4 cycles after RUN, period 4
        bus.MODE = 4'b0000;
        bus.INC  = '0;
        set_inc(0, 8'h40);
        load_and_apply("frac40");
        bus.RUN = 4'b0001;
        for (int k = 1; k <= 16; k++) begin
            ee = {3'b000, (k % 4) == 0};
            tick("frac40_run", ee, 4'hF, 4'b0, 4'hF);
        end

        // Mode 0, INC = 0x55: 85 strobes in 256 cycles
        set_inc(0, 8'h55);
        load_and_apply("frac55");
        bus.RUN = 4'b0001;
        for (int k = 1; k <= 256; k++) begin
            ee = {3'b000, frac_fire(k, 8'h55)};
            tick("frac55_run", ee, 4'hF, 4'b0, 4'hF, k == 1, k == 256, 85);
        end

        // Mode 0, INC = 0xFF: 255 strobes in 256 cycles
        set_inc(0, 8'hFF);
        load_and_apply("fracFF");
        bus.RUN = 4'b0001;
        for (int k = 1; k <= 256; k++) begin
            ee = {3'b000, frac_fire(k, 8'hFF)};
            tick("fracFF_run", ee, 4'hF, 4'b0, 4'hF, k == 1, k == 256, 255);
        end

        // Mode 0, INC = 0: never fires
        set_inc(0, 0);
        load_and_apply("frac00");
        bus.RUN = 4'b0001;
        for (int k = 1; k <= 1000; k++)
            tick("frac00_run", 4'b0, 4'hF, 4'b0, 4'hF, k == 1, k == 1000, 0);

        // Mode 1, N = 0 (ch0) and N = 1 (ch1): strobe every cycle
        bus.MODE = 4'b0011;
        bus.INC  = '0;
        set_inc(0, 0);
        set_inc(1, 1);
        load_and_apply("div01");
        bus.RUN = 4'b0011;
        for (int k = 1; k <= 10; k++) tick("div01_run", 4'b0011, 4'hF, 4'b0, 4'hF);

        // Retune: N = 10 running, LOAD N = 3 mid-period
        bus.MODE = 4'b0001;
        bus.INC  = '0;
        set_inc(0, 10);
        load_and_apply("retune");
        bus.RUN = 4'b0001;
        for (int i = 1; i <= 30; i++) begin
            logic [3:0] pe;
            if (i == 16) begin
                set_inc(0, 3);
                bus.LOAD = 1'b1;
            end
            if (i <= 15) ee = {3'b000, (i % 10) == 1};
            else         ee = {3'b000, (i == 21) || (i == 23) || (i == 26) || (i == 29)};
            if (i == 16)      pe = 4'hF;   // every channel captured
            else if (i >= 17 && i <= 21) pe = 4'b0001;  // stopped channels applied
            else              pe = 4'b0000;
            tick("retune_run", ee, 4'hF, pe, 4'hF);
        end

        // SYNC with N = 2, 3, 4, 6 at staggered phases
        nv = '{2, 3, 4, 6};
        bus.MODE = 4'hF;
        for (int c = 0; c < CH; c++) set_inc(c, nv[c]);
        load_and_apply("sync");
        bus.RUN = 4'b0001; tick("sync_stagger", 4'b0, 4'h0, 4'b0, 4'hF);
        bus.RUN = 4'b0011; tick("sync_stagger", 4'b0, 4'h0, 4'b0, 4'hF);
        bus.RUN = 4'b0111; tick("sync_stagger", 4'b0, 4'h0, 4'b0, 4'hF);
        bus.RUN = 4'b1111;
        for (int i = 0; i < 7; i++) tick("sync_stagger", 4'b0, 4'h0, 4'b0, 4'hF);
        bus.SYNC = 1'b1;
        tick("sync_cycle", 4'b0000, 4'hF, 4'b0, 4'hF);
        for (int j = 1; j <= 25; j++) begin
            for (int c = 0; c < CH; c++) ee[c] = ((j - 1) % nv[c]) == 0;
            tick("sync_lockstep", ee, 4'hF, 4'b0, 4'hF);
        end

        // RESET mid-stream with a pending shadow
        bus.LOAD = 1'b1;
        tick("rst_load", 4'b0, 4'h0, 4'hF, 4'hF);
        rst = 1'b1;
        tick("rst_mid", 4'b0, 4'hF, 4'b0, 4'hF);
        rst = 1'b0;
        for (int k = 1; k <= 20; k++) tick("rst_after", 4'b0, 4'hF, 4'b0, 4'hF);

        // Let the monitor drain the last expectation
        @(negedge clk);
        #1;
        if (sb_q.size() != 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL drain: %0d expectations left, want 0", sb_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
